// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage RISC-V core.
// Handles load-use stalls, taken-branch flushes and mul/div sequencing in EX.
// Optional macro HAZARD_STALL_CNT_EN adds the saturating StallCnt output.
module hazard_ctrl #(
  parameter int MDIV_LAT  = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] IDrs1,
  input  logic [4:0] IDrs2,
  input  logic       IDUseRs1,
  input  logic       IDUseRs2,
  input  logic [4:0] EXrd,
  input  logic       EXMemRead,
  input  logic       EXBranchTaken,
  input  logic       EXMdivStart,
  output logic       StallIF,
  output logic       StallID,
  output logic       StallEX,
  output logic       FlushID,
  output logic       FlushEX,
  output logic       FlushMEM,
  output logic       MdivGo,
  output logic       MdivValid
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] StallCnt
`endif
);

  // Reject parameter values the 8-bit wait counter cannot represent.
  if (MDIV_LAT < 2 || MDIV_LAT > 255 || CNT_WIDTH < 1) begin : g_bad_param
    $error("hazard_ctrl: MDIV_LAT must be 2..255 and CNT_WIDTH >= 1");
  end

  typedef enum logic [0:0] {
    RUN       = 1'b0,
    MDIV_WAIT = 1'b1
  } state_t;

  // The start cycle is already one stall, so the wait phase covers the rest.
  localparam logic [7:0] WAIT_LOAD = 8'(MDIV_LAT - 1);

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;

  // Per-operand load-use match; x0 never produces a hazard.
  logic [4:0] id_rs   [2];
  logic       id_use  [2];
  logic [1:0] src_match;
  logic       load_use;

  assign id_rs[0]  = IDrs1;
  assign id_rs[1]  = IDrs2;
  assign id_use[0] = IDUseRs1;
  assign id_use[1] = IDUseRs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_match[gi] = id_use[gi] && (id_rs[gi] == EXrd);
    end
  endgenerate

  assign load_use = EXMemRead && (EXrd != 5'd0) && (|src_match);

  // State and wait-counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and Mealy outputs; reset forces every output low immediately.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    StallIF    = 1'b0;
    StallID    = 1'b0;
    StallEX    = 1'b0;
    FlushID    = 1'b0;
    FlushEX    = 1'b0;
    FlushMEM   = 1'b0;
    MdivGo     = 1'b0;
    MdivValid  = 1'b0;
    if (reset) begin
      state_next = RUN;
      cnt_next   = 8'd0;
    end else begin
      case (state_reg)
        RUN: begin
          if (EXMdivStart) begin
            // Mul/div wins over a branch in the same cycle.
            MdivGo     = 1'b1;
            StallIF    = 1'b1;
            StallID    = 1'b1;
            StallEX    = 1'b1;
            FlushMEM   = 1'b1;
            state_next = MDIV_WAIT;
            cnt_next   = WAIT_LOAD;
          end else if (EXBranchTaken) begin
            // The ID instruction is squashed, so a load-use match is moot.
            FlushID = 1'b1;
            FlushEX = 1'b1;
          end else if (load_use) begin
            // One bubble lets the load reach MEM where forwarding covers it.
            StallIF = 1'b1;
            StallID = 1'b1;
            FlushEX = 1'b1;
          end
        end
        MDIV_WAIT: begin
          if (cnt_reg != 8'd0) begin
            StallIF  = 1'b1;
            StallID  = 1'b1;
            StallEX  = 1'b1;
            FlushMEM = 1'b1;
            cnt_next = cnt_reg - 8'd1;
          end else begin
            MdivValid  = 1'b1;
            state_next = RUN;
          end
        end
        default: begin
          state_next = RUN;
          cnt_next   = 8'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_reg;

  // Count front-end stall cycles, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (StallIF && (stall_cnt_reg != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign StallCnt = reset ? '0 : stall_cnt_reg;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core; sits beside the forwarding unit.
- Decides the cases forwarding cannot cover: load-use stalls, taken-branch flushes, and sequencing of the multi-cycle mul/div unit in EX.
- Drives the stall and flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers, and the start pulse of the mul/div unit.

Parameters:
- MDIV_LAT, 8: total EX stall cycles for a mul/div op. Legal range 2..255.
- CNT_WIDTH, 32: width of the optional stall counter.

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  synchronous, active-high
- IDrs1  input  5  rs1 of the instruction in ID
- IDrs2  input  5  rs2 of the instruction in ID
- IDUseRs1  input  1  ID instruction reads rs1
- IDUseRs2  input  1  ID instruction reads rs2
- EXrd  input  5  rd of the instruction in EX
- EXMemRead  input  1  EX instruction is a load
- EXBranchTaken  input  1  branch/jump resolved taken in EX
- EXMdivStart  input  1  EX instruction is mul/div
- StallIF  output  1  hold PC and IF/ID
- StallID  output  1  hold ID/EX
- StallEX  output  1  hold EX operands and the mul/div unit
- FlushID  output  1  zero IF/ID at next edge
- FlushEX  output  1  insert bubble into ID/EX at next edge
- FlushMEM  output  1  insert bubble into EX/MEM at next edge
- MdivGo  output  1  one-cycle start pulse to the mul/div unit
- MdivValid  output  1  mul/div result valid this cycle
- StallCnt  output  CNT_WIDTH  optional, see below

Behaviour:
- Outputs are Mealy (state plus current inputs). While reset=1, every output is 0. State and counters update only on the rising clk edge.
- FSM states: RUN and MDIV_WAIT. A 8-bit down-counter cnt is used in MDIV_WAIT.
- Reset (asserted at any time, including mid mul/div): next state is RUN, cnt=0. No MdivGo or MdivValid follows reset.
- RUN evaluates in priority order; only the first matching case applies.
  1. EXMdivStart=1:
     - Assert MdivGo, StallIF, StallID, StallEX, FlushMEM.
     - Next state MDIV_WAIT, cnt=MDIV_LAT-1.
     - EXBranchTaken is ignored this cycle.
  2. EXBranchTaken=1:
     - Assert FlushID and FlushEX for one cycle; no stalls.
     - Any load-use match is ignored because the ID instruction is squashed.
  3. Load-use:
     - Condition: EXMemRead=1, EXrd!=0, and ((IDUseRs1 and IDrs1==EXrd) or (IDUseRs2 and IDrs2==EXrd)).
     - Assert StallIF, StallID, FlushEX for exactly one cycle. State stays RUN.
     - The load advances, so the next cycle re-evaluates with the forwarding path now covering the operand.
  4. Otherwise: all outputs 0.
- MDIV_WAIT:
  - While cnt!=0: assert StallIF, StallID, StallEX, FlushMEM; decrement cnt each cycle.
  - When cnt==0: assert MdivValid; no stall or flush. Next state RUN.
  - All other inputs, including EXMdivStart and EXBranchTaken, are ignored in this state.
- Timing: a mul/div op holds EX for exactly MDIV_LAT stall cycles (start cycle plus MDIV_LAT-1 wait cycles). The release cycle follows, so MdivValid rises MDIV_LAT cycles after MdivGo.
- A mul/div in EX immediately after a release is a new op: it is seen in RUN, and MdivGo fires again.
- x0 is never a hazard source.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined:
  - StallCnt port exists.
  - Increments by 1 on every cycle where StallIF=1 and reset=0.
  - Saturates at all-ones; cleared to 0 by reset.
  - Flush-only cycles do not count.
- Undefined: StallCnt port and its logic are absent. All other behaviour is identical.

Test Plan:
- Load-use on rs1: EXMemRead=1, EXrd=5, IDrs1=5, IDUseRs1=1 -> StallIF=StallID=FlushEX=1 for exactly 1 cycle; next cycle with EXMemRead=0, all outputs 0.
- Load with no hazard: EXrd=0 with IDrs1=0, then EXrd=5 with IDUseRs1=0 and IDrs1=5 -> no stall in either case.
- Taken branch: EXBranchTaken=1 together with a load-use match -> FlushID=FlushEX=1, StallIF=0.
- Mul/div with MDIV_LAT=8: EXMdivStart=1 -> MdivGo pulse 1 cycle; StallIF/StallID/StallEX/FlushMEM high for 8 cycles; MdivValid=1 on the 9th cycle; then RUN. Back-to-back mul/div -> second MdivGo on the cycle after MdivValid.
- Reset mid-op: reset on the 4th MDIV_WAIT cycle -> all outputs 0 the same cycle; next cycle in RUN with EXMdivStart=0 -> no stall and no MdivValid.
- HAZARD_STALL_CNT_EN with one load-use plus one mul/div (MDIV_LAT=8) -> StallCnt=9; one taken branch leaves it unchanged.
